// File: rtl/mux4to1_pkg.sv
// Shared constants and select decode for the registered 4:1 lane mux.
package mux4to1_pkg;

  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;

  localparam logic [SEL_W-1:0] SEL_L0 = 2'b00;
  localparam logic [SEL_W-1:0] SEL_L1 = 2'b01;
  localparam logic [SEL_W-1:0] SEL_L2 = 2'b10;
  localparam logic [SEL_W-1:0] SEL_L3 = 2'b11;

  function automatic logic [NUM_LANES-1:0] onehot4(input logic [SEL_W-1:0] sel);
    onehot4 = 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/mux4to1_core.sv
// Combinational W-bit 4:1 lane select; an unknown select yields X in simulation.
module mux4to1_core
  import mux4to1_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [NUM_LANES*W-1:0] data,
  input  logic [SEL_W-1:0]       sel,
  output logic [W-1:0]           y
);

  always_comb begin
    y = 'x;
    case (sel)
      SEL_L0:  y = data[0*W +: W];
      SEL_L1:  y = data[1*W +: W];
      SEL_L2:  y = data[2*W +: W];
      SEL_L3:  y = data[3*W +: W];
      default: y = 'x;
    endcase
  end

endmodule

// File: rtl/mux4to1_reg.sv
// Registered 4:1 lane mux with valid flag and one-hot select decode.
// Define MUX4TO1_REG_COMB_OUT_EN to expose the unregistered selection on y_comb_out.
module mux4to1_reg
  import mux4to1_pkg::*;
#(
  parameter int            W       = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [NUM_LANES*W-1:0] data_in,
  input  logic [SEL_W-1:0]       sel_in,
  input  logic                   valid_in,
  output logic [W-1:0]           y_out,
  output logic                   valid_out,
  output logic [NUM_LANES-1:0]   sel_onehot_out
`ifdef MUX4TO1_REG_COMB_OUT_EN
  ,
  output logic [W-1:0]           y_comb_out
`endif
);

  logic [W-1:0] lane_sel;

  mux4to1_core #(.W(W)) u_core (
    .data (data_in),
    .sel  (sel_in),
    .y    (lane_sel)
  );

`ifdef MUX4TO1_REG_COMB_OUT_EN
  assign y_comb_out = lane_sel;
`endif

  // y_out and the decode hold when valid_in is low; only valid_out tracks it
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      y_out          <= RST_VAL;
      valid_out      <= 1'b0;
      sel_onehot_out <= '0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        y_out          <= lane_sel;
        sel_onehot_out <= onehot4(sel_in);
      end
    end
  end

endmodule

// File: tb/tb_mux4to1_reg.sv
// Scoreboard bench for mux4to1_reg: a W=1 and a W=8 instance on a shared clock/reset.
module tb_mux4to1_reg;

  typedef struct {
    logic [7:0] y;
    logic [3:0] oh;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [3:0]  d1 = '0;
  logic [1:0]  s1 = '0;
  logic        v1 = 1'b0;
  logic        y1;
  logic        vo1;
  logic [3:0]  oh1;

  logic [31:0] d8 = '0;
  logic [1:0]  s8 = '0;
  logic        v8 = 1'b0;
  logic [7:0]  y8;
  logic        vo8;
  logic [3:0]  oh8;

`ifdef MUX4TO1_REG_COMB_OUT_EN
  logic        yc1;
  logic [7:0]  yc8;
`endif

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  mux4to1_reg #(.W(1)) dut1 (
    .clk_in         (clk),
    .rst_in         (rst),
    .data_in        (d1),
    .sel_in         (s1),
    .valid_in       (v1),
    .y_out          (y1),
    .valid_out      (vo1),
    .sel_onehot_out (oh1)
`ifdef MUX4TO1_REG_COMB_OUT_EN
    ,
    .y_comb_out     (yc1)
`endif
  );

  mux4to1_reg #(.W(8), .RST_VAL(8'h5A)) dut8 (
    .clk_in         (clk),
    .rst_in         (rst),
    .data_in        (d8),
    .sel_in         (s8),
    .valid_in       (v8),
    .y_out          (y8),
    .valid_out      (vo8),
    .sel_onehot_out (oh8)
`ifdef MUX4TO1_REG_COMB_OUT_EN
    ,
    .y_comb_out     (yc8)
`endif
  );

  task automatic test_reset();
    @(negedge clk);
    d1 = 4'b1111; s1 = 2'b00; v1 = 1'b1;
    d8 = {8'hDD, 8'hCC, 8'hBB, 8'hAA}; s8 = 2'b10; v8 = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (y1 !== 1'b0) begin errors++; $display("FAIL reset_async_y1 got %b want 0", y1); end
    checks++; if (vo1 !== 1'b0) begin errors++; $display("FAIL reset_async_valid1 got %b want 0", vo1); end
    checks++; if (oh1 !== 4'b0000) begin errors++; $display("FAIL reset_async_oh1 got %b want 0000", oh1); end
    checks++; if (y8 !== 8'h5A) begin errors++; $display("FAIL reset_async_y8 got %h want 5a", y8); end
    checks++; if (vo8 !== 1'b0) begin errors++; $display("FAIL reset_async_valid8 got %b want 0", vo8); end
    checks++; if (oh8 !== 4'b0000) begin errors++; $display("FAIL reset_async_oh8 got %b want 0000", oh8); end
    // valid stays high across an edge while in reset: the capture must be discarded
    @(posedge clk);
    #1;
    checks++; if (y1 !== 1'b0 || vo1 !== 1'b0 || oh1 !== 4'b0000)
      begin errors++; $display("FAIL reset_held_1 got y=%b v=%b oh=%b want 0 0 0000", y1, vo1, oh1); end
    checks++; if (y8 !== 8'h5A || vo8 !== 1'b0)
      begin errors++; $display("FAIL reset_held_8 got y=%h v=%b want 5a 0", y8, vo8); end
    @(negedge clk);
    rst = 1'b0; v1 = 1'b0; v8 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++; if (y1 !== 1'b0 || vo1 !== 1'b0 || oh1 !== 4'b0000)
        begin errors++; $display("FAIL reset_idle_1[%0d] got y=%b v=%b oh=%b want 0 0 0000", i, y1, vo1, oh1); end
      checks++; if (y8 !== 8'h5A || vo8 !== 1'b0 || oh8 !== 4'b0000)
        begin errors++; $display("FAIL reset_idle_8[%0d] got y=%h v=%b oh=%b want 5a 0 0000", i, y8, vo8, oh8); end
    end
  endtask

  task automatic test_lanes();
    logic [3:0] td [6] = '{4'b0101, 4'b0101, 4'b0111, 4'b1000, 4'b0111, 4'b1101};
    logic [1:0] ts [6] = '{2'b00,   2'b01,   2'b01,   2'b10,   2'b10,   2'b11};
    logic       ty [6] = '{1'b1,    1'b0,    1'b1,    1'b0,    1'b1,    1'b1};
    logic [3:0] to [6] = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000};
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      d1 = td[i]; s1 = ts[i]; v1 = 1'b1;
      q.push_back('{y: {7'b0, ty[i]}, oh: to[i]});
`ifdef MUX4TO1_REG_COMB_OUT_EN
      #1;
      checks++; if (yc1 !== ty[i]) begin errors++; $display("FAIL lanes_comb[%0d] got %b want %b", i, yc1, ty[i]); end
`endif
      @(posedge clk);
      #1;
      checks++;
      if (q.size() == 0) begin
        errors++; $display("FAIL lanes_queue[%0d] got empty want entry", i);
      end else begin
        e = q.pop_front();
        if (y1 !== e.y[0] || vo1 !== 1'b1 || oh1 !== e.oh) begin
          errors++;
          $display("FAIL lanes[%0d] got y=%b v=%b oh=%b want y=%b v=1 oh=%b", i, y1, vo1, oh1, e.y[0], e.oh);
        end
      end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    @(negedge clk);
    d1 = 4'b0101; s1 = 2'b00; v1 = 1'b1;
    q.push_back('{y: 8'h01, oh: 4'b0001});
    @(posedge clk);
    #1;
    checks++;
    if (q.size() == 0) begin
      errors++; $display("FAIL hold_queue got empty want entry");
    end else begin
      e = q.pop_front();
      if (y1 !== e.y[0] || vo1 !== 1'b1 || oh1 !== e.oh) begin
        errors++; $display("FAIL hold_capture got y=%b v=%b oh=%b want y=%b v=1 oh=%b", y1, vo1, oh1, e.y[0], e.oh);
      end
    end
    @(negedge clk);
    v1 = 1'b0; s1 = 2'b01; d1 = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++; if (y1 !== 1'b1 || vo1 !== 1'b0 || oh1 !== 4'b0001)
        begin errors++; $display("FAIL hold[%0d] got y=%b v=%b oh=%b want 1 0 0001", i, y1, vo1, oh1); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] lane [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [3:0] ohx  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_t e;
    @(negedge clk);
    d8 = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      s8 = 2'(i); v8 = 1'b1;
      q.push_back('{y: lane[i], oh: ohx[i]});
`ifdef MUX4TO1_REG_COMB_OUT_EN
      #0;
      checks++; if (yc8 !== lane[i]) begin errors++; $display("FAIL b2b_comb[%0d] got %h want %h", i, yc8, lane[i]); end
`endif
      @(posedge clk);
      #1;
      checks++;
      if (q.size() == 0) begin
        errors++; $display("FAIL b2b_queue[%0d] got empty want entry", i);
      end else begin
        e = q.pop_front();
        if (y8 !== e.y || vo8 !== 1'b1 || oh8 !== e.oh) begin
          errors++; $display("FAIL b2b[%0d] got y=%h v=%b oh=%b want y=%h v=1 oh=%b", i, y8, vo8, oh8, e.y, e.oh);
        end
      end
    end
    @(negedge clk);
    v8 = 1'b0; s8 = 2'b00;
    @(posedge clk);
    #1;
    checks++; if (y8 !== 8'hDD || vo8 !== 1'b0 || oh8 !== 4'b1000)
      begin errors++; $display("FAIL b2b_idle got y=%h v=%b oh=%b want dd 0 1000", y8, vo8, oh8); end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d want 0", q.size()); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_lanes();
    test_hold();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
